// File: rtl/mem_word_bridge.sv
// Word-to-byte bridge: one 32-bit CPU access becomes four big-endian byte accesses on a sync-read byte RAM.
// Optional: define MEM_BRIDGE_SUBWORD_READ_EN so reads only enable and keep the lanes selected by sel.
module mem_word_bridge #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [3:0]    sel,
    input  logic [31:0]   dat_i,
    output logic [31:0]   dat_o,
    output logic          ack,
    output logic          busy,
    output logic [AW-1:0] mem_adr,
    output logic [7:0]    mem_dat_o,
    input  logic [7:0]    mem_dat_i,
    output logic          mem_we,
    output logic          mem_en
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic [AW-3:0]   wadr_q, wadr_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     wdat_q, wdat_d;

    logic [31:0]     dat_o_q, dat_o_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic [AW-1:0]   mem_adr_q, mem_adr_d;
    logic [7:0]      mem_dat_o_q, mem_dat_o_d;
    logic            mem_we_q, mem_we_d;
    logic            mem_en_q, mem_en_d;

    logic [7:0]      wbyte [4];
    logic [3:0]      lane_keep;
    logic            cap_en;
    logic [1:0]      cap_lane;
    logic            lane_sel_d;
    logic            unused_adr_lsb;

    assign unused_adr_lsb = ^adr[1:0];

    // Lane gi is byte offset gi from the word base: lane 0 is bits 31:24.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wbyte[gi] = wdat_d[31-8*gi -: 8];
`ifdef MEM_BRIDGE_SUBWORD_READ_EN
            assign lane_keep[gi] = sel_q[3-gi];
`else
            assign lane_keep[gi] = 1'b1;
`endif
            assign dat_o_d[31-8*gi -: 8] =
                (cap_en && cap_lane == 2'(gi)) ? (lane_keep[gi] ? mem_dat_i : 8'h00)
                                               : dat_o_q[31-8*gi -: 8];
        end
    endgenerate

    // Read byte k returns one cycle after issue; in WAIT k has wrapped to 0, so k-1 is lane 3.
    assign cap_en   = ((state_q == ST_XFER) && (k_q != 2'd0) && !we_q) || (state_q == ST_WAIT);
    assign cap_lane = k_q - 2'd1;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wadr_d  = wadr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_XFER;
                    k_d     = 2'd0;
                    wadr_d  = adr[AW-1:2];
                    we_d    = we;
                    sel_d   = sel;
                    wdat_d  = dat_i;
                end
            end
            ST_XFER: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = we_q ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs are registered, so they are computed from the next state.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_adr_d   = '0;
        mem_dat_o_d = 8'h00;
        lane_sel_d  = sel_d[~k_d];
        if (state_d == ST_XFER) begin
            mem_adr_d   = {wadr_d, k_d};
            mem_dat_o_d = wbyte[k_d];
            if (we_d) begin
                mem_en_d = lane_sel_d;
                mem_we_d = lane_sel_d;
            end else begin
`ifdef MEM_BRIDGE_SUBWORD_READ_EN
                mem_en_d = lane_sel_d;
`else
                mem_en_d = 1'b1;
`endif
            end
        end
        ack_d  = (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            k_q         <= 2'd0;
            wadr_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            wdat_q      <= 32'h0;
            dat_o_q     <= 32'h0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_adr_q   <= '0;
            mem_dat_o_q <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wadr_q      <= wadr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wdat_q      <= wdat_d;
            dat_o_q     <= dat_o_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            mem_adr_q   <= mem_adr_d;
            mem_dat_o_q <= mem_dat_o_d;
            mem_we_q    <= mem_we_d;
            mem_en_q    <= mem_en_d;
        end
    end

    assign dat_o     = dat_o_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign mem_adr   = mem_adr_q;
    assign mem_dat_o = mem_dat_o_q;
    assign mem_we    = mem_we_q;
    assign mem_en    = mem_en_q;

endmodule

// File: tb/tb_mem_word_bridge.sv
// Directed bench for mem_word_bridge against a behavioural sync-read byte RAM.
module tb_mem_word_bridge;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [3:0]    sel = 4'h0;
    logic [31:0]   dat_i = 32'h0;
    logic [31:0]   dat_o;
    logic          ack;
    logic          busy;
    logic [AW-1:0] mem_adr;
    logic [7:0]    mem_dat_o;
    logic [7:0]    mem_dat_i;
    logic          mem_we;
    logic          mem_en;

    mem_word_bridge #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .sel(sel),
        .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .busy(busy),
        .mem_adr(mem_adr), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
        .mem_we(mem_we), .mem_en(mem_en)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] mem_rd;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_adr] <= mem_dat_o;
            else        mem_rd <= mem[mem_adr];
        end
    end
    assign mem_dat_i = mem_rd;

    int cyc = 0;
    int ack_total = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ack) ack_total <= ack_total + 1;
    end

    int total = 0;
    int bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    logic [7:0]    en_log, we_log;
    logic [AW-1:0] adr_log [1:8];
    logic [7:0]    dat_log [1:8];
    int            ack_at, n_ack;
    logic          busy_c1;
    logic [31:0]   rdata;

    // Drives one request at C0 and samples C1..C8 mid-cycle.
    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [3:0] s,
                       input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        ack_at = 0; n_ack = 0; en_log = 8'h0; we_log = 8'h0; rdata = 32'h0;
        @(negedge clk);
        req = 1'b0;
        busy_c1 = busy;
        for (int c = 1; c <= 8; c++) begin
            en_log[c-1] = mem_en;
            we_log[c-1] = mem_we;
            adr_log[c]  = mem_adr;
            dat_log[c]  = mem_dat_o;
            if (ack) begin
                n_ack++;
                if (ack_at == 0) begin
                    ack_at = c;
                    rdata  = dat_o;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_ack(output int at, output logic found);
        found = 1'b0;
        at = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ack) begin
                found = 1'b1;
                at = cyc;
            end
        end
    endtask

    logic [31:0] exp_en, exp_dat;
    int t0, t1, t2, t3, a0;
    logic f1, f2, f3;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dat_o", dat_o, 32'h0);
        chk("rst_ctl", {ack, busy, mem_en, mem_we}, 4'h0);
        chk("rst_mem_bus", {mem_adr, mem_dat_o}, '0);
        rst = 1'b1;

        // Full word write
        txn(1'b1, 14'h0100, 4'hF, 32'h11223344);
        chk("wr_mem", mem_word(14'h0100), 32'h11223344);
        chk("wr_we_cycles", we_log, 8'h0F);
        chk("wr_en_cycles", en_log, 8'h0F);
        chk("wr_ack_cycle", ack_at, 5);
        chk("wr_ack_count", n_ack, 1);
        chk("wr_busy_c1", busy_c1, 1'b1);
        chk("wr_adr_c1", adr_log[1], 14'h0100);
        chk("wr_adr_c4", adr_log[4], 14'h0103);
        chk("wr_byte_c2", dat_log[2], 8'h22);

        // Full word read, low address bits ignored
        txn(1'b0, 14'h0103, 4'hF, 32'h0);
        chk("rd_adr_c1", adr_log[1], 14'h0100);
        chk("rd_adr_c3", adr_log[3], 14'h0102);
        chk("rd_adr_c4", adr_log[4], 14'h0103);
        chk("rd_en_cycles", en_log, 8'h0F);
        chk("rd_we_cycles", we_log, 8'h00);
        chk("rd_ack_cycle", ack_at, 6);
        chk("rd_data", rdata, 32'h11223344);
        chk("rd_data_held", dat_o, 32'h11223344);

        // Single-lane write
        txn(1'b1, 14'h0100, 4'b0100, 32'hAABBCCDD);
        chk("sw_en_cycles", en_log, 8'h02);
        chk("sw_ack_cycle", ack_at, 5);
        chk("sw_mem", mem_word(14'h0100), 32'h11BB3344);
        txn(1'b0, 14'h0100, 4'hF, 32'h0);
        chk("sw_readback", rdata, 32'h11BB3344);

        // Sub-word read
`ifdef MEM_BRIDGE_SUBWORD_READ_EN
        exp_en = 32'h09; exp_dat = 32'h11000044;
`else
        exp_en = 32'h0F; exp_dat = 32'h11BB3344;
`endif
        txn(1'b0, 14'h0100, 4'b1001, 32'h0);
        chk("sr_en_cycles", en_log, exp_en);
        chk("sr_data", rdata, exp_dat);
        chk("sr_ack_cycle", ack_at, 6);

        // Back-to-back write, write, read with req held high
        @(negedge clk);
        a0 = ack_total; t0 = cyc;
        req = 1'b1; we = 1'b1; adr = 14'h0108; sel = 4'hF; dat_i = 32'hCAFEF00D;
        wait_ack(t1, f1);
        adr = 14'h010C; dat_i = 32'h0BADBEEF;
        wait_ack(t2, f2);
        we = 1'b0; adr = 14'h0108;
        @(negedge clk);
        @(negedge clk);
        req = 1'b0;
        wait_ack(t3, f3);
        rdata = dat_o;
        chk("b2b_found", {f1, f2, f3}, 3'b111);
        chk("b2b_first_ack", t1 - t0, 5);
        chk("b2b_wr_gap", t2 - t1, 6);
        chk("b2b_rd_gap", t3 - t2, 7);
        chk("b2b_rd_data", rdata, 32'hCAFEF00D);
        repeat (10) @(negedge clk);
        chk("b2b_ack_count", ack_total - a0, 3);
        chk("b2b_mem2", mem_word(14'h010C), 32'h0BADBEEF);

        // Reset abort mid-write
        txn(1'b1, 14'h0200, 4'hF, 32'hEEEEEEEE);
        @(negedge clk);
        a0 = ack_total;
        req = 1'b1; we = 1'b1; adr = 14'h0200; sel = 4'hF; dat_i = 32'h55667788;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_ctl", {ack, busy, mem_en, mem_we}, 4'h0);
        chk("abort_bus", {mem_adr, mem_dat_o}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_ack", ack_total - a0, 0);
        chk("abort_mem", mem_word(14'h0200), 32'h5566EEEE);
        txn(1'b1, 14'h0200, 4'hF, 32'h55667788);
        chk("post_abort_ack", ack_at, 5);
        chk("post_abort_mem", mem_word(14'h0200), 32'h55667788);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
